// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch unit.
//   - fetch_state_e : FSM state encoding (IDLE / RUN / FLUSH)
//   - DEF_*         : default parameter values used by fetch_unit
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } fetch_state_e;

   localparam int DEF_PC_WIDTH    = 10;
   localparam int DEF_INSTR_WIDTH = 32;
   localparam int DEF_DEPTH       = 4;
   localparam int DEF_RESET_PC    = 0;

endpackage : fetch_unit_pkg

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Circular FIFO holding fetched {pc, instruction} entries.
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   push/push_data : write an entry at the tail (accepted when not full, or
//                    when a pop happens in the same cycle)
//   pop            : drop the head entry (ignored when empty)
//   flush          : empty the queue; wins over push and pop
//   head_data      : current head entry (meaningful when !empty)
//   full, empty    : occupancy flags
//   count          : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 42
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;
   localparam logic [AW-1:0]    PTR_ONE = AW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] FULL_V  = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign empty     = (count_q == '0);
   assign full      = (count_q == FULL_V);
   assign count     = count_q;
   assign head_data = mem_q[rd_ptr_q];

   // A push into a full queue is legal when the head leaves in the same cycle.
   assign pop_ok  = pop && !empty && !flush;
   assign push_ok = push && (!full || pop_ok) && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; entries are only observed when counted valid.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

endmodule : fetch_queue

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Sequential instruction prefetcher: issues word reads to an instruction
// memory with fixed 1-cycle read latency and buffers responses in a FIFO
// toward a valid/ready consumer. A redirect flushes everything and restarts
// fetching at the new target.
//
// Ports:
//   clock, reset                : rising-edge clock, synchronous active-high reset
//   im_enable/im_read/im_address: memory strobe (read == enable) and word address
//   im_rdata                    : memory data, valid the cycle after the strobe
//   instr_valid/instr_ready     : downstream handshake
//   instr_data/instr_pc         : delivered instruction and its address
//   redirect_valid/redirect_pc  : single-cycle branch/jump redirect
//
// Handshake: an instruction transfers in any cycle where instr_valid and
// instr_ready are both high; while instr_valid is high and instr_ready is low
// instr_data/instr_pc hold their values. There is no ready toward the memory.
//
// Build option: define FETCH_BYPASS_EN to forward a response straight to the
// output when the queue is empty (one cycle less latency).
// -----------------------------------------------------------------------------
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int PC_WIDTH    = DEF_PC_WIDTH,
   parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int RESET_PC    = DEF_RESET_PC
) (
   input  logic                   clock,
   input  logic                   reset,
   output logic                   im_enable,
   output logic                   im_read,
   output logic [PC_WIDTH-1:0]    im_address,
   input  logic [INSTR_WIDTH-1:0] im_rdata,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [INSTR_WIDTH-1:0] instr_data,
   output logic [PC_WIDTH-1:0]    instr_pc,
   input  logic                   redirect_valid,
   input  logic [PC_WIDTH-1:0]    redirect_pc
);

   localparam int ENTRY_W = PC_WIDTH + INSTR_WIDTH;
   localparam int CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);
   localparam logic [PC_WIDTH-1:0] PC_ONE     = PC_WIDTH'(1);
   localparam logic [CNT_W:0]      DEPTH_V    = (CNT_W + 1)'(DEPTH);

   fetch_state_e        state_q, state_d;
   logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
   logic                inflight_q, inflight_d;

   logic                issue;
   logic                resp_live;
   logic                bypass;
   logic                q_push, q_pop, q_full, q_empty;
   logic [CNT_W-1:0]    q_count;
   logic [CNT_W:0]      outstanding;
   logic [ENTRY_W-1:0]  q_head;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         fetch_pc_q    <= RESET_PC_V;
         inflight_q    <= 1'b0;
         inflight_pc_q <= RESET_PC_V;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         state_d = ST_FLUSH;
      end else begin
         case (state_q)
            ST_IDLE:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   // Credit counts what is already buffered plus the read still in flight;
   // a pop in this same cycle does not free a slot until next cycle.
   always_comb begin
      outstanding = {1'b0, q_count} + {{CNT_W{1'b0}}, inflight_q};
      issue       = !reset && (state_q == ST_RUN) && !redirect_valid &&
                    !q_full && (outstanding < DEPTH_V);
   end

   assign im_enable  = issue;
   assign im_read    = issue;
   assign im_address = reset ? RESET_PC_V : fetch_pc_q;

   // ---------------- fetch PC / in-flight tracking ----------------
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
      end else if (issue) begin
         fetch_pc_d    = fetch_pc_q + PC_ONE;
         inflight_pc_d = fetch_pc_q;
      end
   end

   // A response arriving in a redirect cycle belongs to the old path.
   assign resp_live = inflight_q && !redirect_valid && !reset;

`ifdef FETCH_BYPASS_EN
   assign bypass = resp_live && q_empty;
`else
   assign bypass = 1'b0;
`endif

   assign instr_valid = !reset && (!q_empty || bypass);
   assign q_pop       = !q_empty && instr_valid && instr_ready && !redirect_valid;
   // A bypassed response consumed on the spot never enters the queue.
   assign q_push      = resp_live && !(bypass && instr_ready);

   always_comb begin
      instr_data = '0;
      instr_pc   = '0;
      if (!reset) begin
         if (!q_empty) begin
            instr_data = q_head[INSTR_WIDTH-1:0];
            instr_pc   = q_head[ENTRY_W-1:INSTR_WIDTH];
         end else if (bypass) begin
            instr_data = im_rdata;
            instr_pc   = inflight_pc_q;
         end
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_queue (
      .clock     (clock),
      .reset     (reset),
      .push      (q_push),
      .push_data ({inflight_pc_q, im_rdata}),
      .pop       (q_pop),
      .flush     (redirect_valid),
      .head_data (q_head),
      .full      (q_full),
      .empty     (q_empty),
      .count     (q_count)
   );

endmodule : fetch_unit
